// File: rtl/seg_display_mux.sv
// Four-digit common-anode seven-segment scanner for BCD clock digits.
// Shows a per-frame snapshot of the digits and blinks one digit pair while time is being adjusted.
module seg_display_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] min_ten,
  input  logic [3:0] min_one,
  input  logic [3:0] sec_ten,
  input  logic [3:0] sec_one,
  input  logic       adjust,
  input  logic       blink_sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

  logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic [3:0]    snap_q [4];
  logic [3:0]    snap_d [4];
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          refresh_wrap;
  logic          blink_wrap;
  logic          blanked;
  logic [3:0]    cur_digit;

  // Active-low {g,f,e,d,c,b,a}; non-BCD codes light nothing.
  function automatic logic [6:0] decode_bcd(input logic [3:0] d);
    case (d)
      4'd0:    decode_bcd = 7'b1000000;
      4'd1:    decode_bcd = 7'b1111001;
      4'd2:    decode_bcd = 7'b0100100;
      4'd3:    decode_bcd = 7'b0110000;
      4'd4:    decode_bcd = 7'b0011001;
      4'd5:    decode_bcd = 7'b0010010;
      4'd6:    decode_bcd = 7'b0000010;
      4'd7:    decode_bcd = 7'b1111000;
      4'd8:    decode_bcd = 7'b0000000;
      4'd9:    decode_bcd = 7'b0010000;
      default: decode_bcd = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    refresh_wrap  = (refresh_cnt_q == REFRESH_LAST);
    refresh_cnt_d = refresh_wrap ? '0 : refresh_cnt_q + 1'b1;
    idx_d         = refresh_wrap ? idx_q + 2'd1 : idx_q;
  end

  // Capture all digits together as the scan returns to digit 0, so a frame is coherent.
  always_comb begin
    for (int i = 0; i < 4; i++) snap_d[i] = snap_q[i];
    if (refresh_wrap && (idx_q == 2'd3)) begin
      snap_d[0] = sec_one;
      snap_d[1] = sec_ten;
      snap_d[2] = min_one;
      snap_d[3] = min_ten;
    end
  end

  always_comb begin
    blink_wrap  = (blink_cnt_q == BLINK_LAST);
    blink_cnt_d = '0;
    phase_d     = 1'b0;
    if (adjust) begin
      blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
      phase_d     = blink_wrap ? ~phase_q : phase_q;
    end
  end

  // adjust and blink_sel act live; only the digit values wait for the next snapshot.
  always_comb begin
    cur_digit = snap_q[idx_q];
    blanked   = adjust && phase_q && (blink_sel == idx_q[1]);
    an_d      = 4'b1111;
    seg_d     = 7'b1111111;
    dp_d      = 1'b1;
    if (!blanked) begin
      an_d[idx_q] = 1'b0;
      seg_d       = decode_bcd(cur_digit);
      dp_d        = (idx_q != 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt_q <= '0;
      idx_q         <= 2'd0;
      blink_cnt_q   <= '0;
      phase_q       <= 1'b0;
      for (int i = 0; i < 4; i++) snap_q[i] <= 4'd0;
      an_q          <= 4'b1111;
      seg_q         <= 7'b1111111;
      dp_q          <= 1'b1;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      phase_q       <= phase_d;
      for (int i = 0; i < 4; i++) snap_q[i] <= snap_d[i];
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux with a 4-cycle digit slot and 8-cycle blink phase.
// Expected frames are built from hand-written digit tables and blanking masks.
module tb_seg_display_mux;

  logic       clk;
  logic       reset;
  logic [3:0] min_ten, min_one, sec_ten, sec_one;
  logic       adjust, blink_sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_checks = 0;
  int n_fail   = 0;
  int pos      = 0;

  seg_display_mux #(.REFRESH_DIV(4), .BLINK_DIV(8)) dut (
    .clk(clk), .reset(reset),
    .min_ten(min_ten), .min_one(min_one), .sec_ten(sec_ten), .sec_one(sec_one),
    .adjust(adjust), .blink_sel(blink_sel),
    .an(an), .seg(seg), .dp(dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] exp_seg(input logic [3:0] d);
    case (d)
      4'd0:    exp_seg = 7'b1000000;
      4'd1:    exp_seg = 7'b1111001;
      4'd2:    exp_seg = 7'b0100100;
      4'd3:    exp_seg = 7'b0110000;
      4'd4:    exp_seg = 7'b0011001;
      4'd5:    exp_seg = 7'b0010010;
      4'd6:    exp_seg = 7'b0000010;
      4'd7:    exp_seg = 7'b1111000;
      4'd8:    exp_seg = 7'b0000000;
      4'd9:    exp_seg = 7'b0010000;
      default: exp_seg = 7'b1111111;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] expv);
    n_checks++;
    assert ({an, seg, dp} === expv)
    else begin
      n_fail++;
      $error("FAIL %s pos=%0d: observed an/seg/dp=%b expected %b", tag, pos, {an, seg, dp}, expv);
    end
  endtask

  // snap_exp nibble k is the digit shown at scan position k; blank_mask marks blanked positions.
  task automatic scan(input int n, input logic [15:0] snap_exp, input logic [3:0] blank_mask,
                      input string tag);
    int k;
    logic [3:0] d;
    logic [3:0] an_exp;
    for (int i = 0; i < n; i++) begin
      step();
      k = pos / 4;
      d = snap_exp[k*4 +: 4];
      an_exp = 4'b1111;
      an_exp[k] = 1'b0;
      if (blank_mask[k]) check(tag, 12'hFFF);
      else check(tag, {an_exp, exp_seg(d), (k != 2)});
      pos = (pos + 1) % 16;
    end
  endtask

  initial begin
    reset = 1'b1;
    min_ten = 4'd1; min_one = 4'd2; sec_ten = 4'd3; sec_one = 4'd4;
    adjust = 1'b0; blink_sel = 1'b0;

    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_hold", 12'hFFF);
    end

    reset = 1'b0;
    pos = 0;
    min_ten = 4'd1; min_one = 4'd2; sec_ten = 4'd5; sec_one = 4'd9;
    scan(16, 16'h0000, 4'b0000, "first_frame_zero");

    scan(8, 16'h1259, 4'b0000, "snapshot_1259");
    min_ten = 4'd7; min_one = 4'd6; sec_ten = 4'd3; sec_one = 4'hC;
    scan(8, 16'h1259, 4'b0000, "midframe_hold");

    scan(4, 16'h763C, 4'b0000, "invalid_bcd");

    adjust = 1'b1; blink_sel = 1'b0;
    scan(8, 16'h763C, 4'b0000, "blink_sec_vis1");
    scan(8, 16'h763C, 4'b0011, "blink_sec_blank1");
    scan(8, 16'h763C, 4'b0000, "blink_sec_vis2");
    scan(8, 16'h763C, 4'b0011, "blink_sec_blank2");

    adjust = 1'b0;
    scan(12, 16'h763C, 4'b0000, "adjust_off");

    adjust = 1'b1; blink_sel = 1'b1;
    scan(8, 16'h763C, 4'b0000, "blink_min_vis");
    scan(2, 16'h763C, 4'b1100, "blink_min_blank");
    adjust = 1'b0;
    scan(2, 16'h763C, 4'b0000, "adjust_drop");
    adjust = 1'b1;
    scan(4, 16'h763C, 4'b0000, "phase_restart");
    adjust = 1'b0;

    scan(8, 16'h763C, 4'b0000, "pre_reset");
    reset = 1'b1;
    step();
    check("midframe_reset", 12'hFFF);
    reset = 1'b0;
    pos = 0;
    scan(16, 16'h0000, 4'b0000, "after_reset");
    scan(4, 16'h763C, 4'b0000, "resnap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_display_mux.md
Name: seg_display_mux

Overview:
- Downstream consumer of the clock counter's four BCD digits (min_ten, min_one, sec_ten, sec_one).
- Time-multiplexes the digits onto a 4-digit common-anode seven-segment display, with active-low anodes and segments.
- Takes a frame-coherent snapshot of the digits so a displayed frame never mixes old and new time values.
- Blanks the minute or second pair at a fixed rate while the user is adjusting time.

Parameters:
- REFRESH_DIV, 100000, clock cycles each digit is driven; one frame = 4*REFRESH_DIV cycles.
- BLINK_DIV, 25000000, clock cycles per blink phase; full blink period = 2*BLINK_DIV cycles.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- min_ten  input  4  BCD minutes tens digit.
- min_one  input  4  BCD minutes ones digit.
- sec_ten  input  4  BCD seconds tens digit.
- sec_one  input  4  BCD seconds ones digit.
- adjust  input  1  1 = adjust mode; blinking enabled.
- blink_sel  input  1  pair to blink: 1 = minutes (digits 3,2), 0 = seconds (digits 1,0).
- an  output  4  anode enables, active-low; an[0] is the rightmost digit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low; used as the min/sec separator.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high and is sampled on posedge clk. It has priority over all other activity and takes effect at the next edge even mid-frame.
- Reset values:
  - refresh_cnt = 0, idx = 0, blink_cnt = 0, phase = 0.
  - snap[3:0] digits = 0.
  - an = 4'b1111, seg = 7'b1111111, dp = 1.
- Refresh counter: refresh_cnt counts 0..REFRESH_DIV-1 and wraps to 0. When it wraps, idx advances 0→1→2→3→0.
- Digit mapping: idx 0 = sec_one, 1 = sec_ten, 2 = min_one, 3 = min_ten. Digit k drives an[k] low; the other anodes are high.
- Snapshot:
  - All four inputs are captured into snap on the same edge at which idx advances 3→0.
  - The inputs are not captured at any other time.
  - The first frame after reset therefore displays 0000.
- Output timing:
  - an, seg and dp are registered from the current idx, snap and phase, giving 1-cycle latency.
  - Example: the edge that sets idx = k is followed one edge later by an showing digit k.
  - First edge after reset release: an = 4'b1110, seg = 7'b1000000.
- Decode (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Values 10–15 give seg = 1111111; the anode is still driven.
- dp: 0 when idx == 2, else 1. It forms the separator between min_one and sec_ten and is suppressed together with the digit when that digit is blanked.
- Blink:
  - While adjust = 0: blink_cnt is held at 0, phase is held at 0, and no blanking occurs.
  - While adjust = 1: blink_cnt counts 0..BLINK_DIV-1, and phase toggles each time it wraps.
  - When adjust rises, the display starts in the visible phase (phase = 0) for BLINK_DIV cycles.
  - Blanking condition: adjust = 1 AND phase = 1 AND the current digit is in the selected pair.
  - When blanked: the corresponding anode is driven high (all of an = 1111), seg = 1111111 and dp = 1.
- Live inputs:
  - A change of blink_sel or adjust affects the output register at the next edge; no frame alignment is applied.
  - A change of the digit inputs affects the display only at the next snapshot.
- Simultaneous events: a refresh wrap and a blink wrap on the same edge are independent; both take effect.
- Widths:
  - refresh_cnt and blink_cnt are sized by $clog2 of their parameters, minimum 1 bit.
  - No arithmetic is performed on the digit values.

Test Plan:
(Bench uses REFRESH_DIV = 4, BLINK_DIV = 8.)
- Reset check: hold reset for 3 cycles with inputs = 1,2,3,4 → an = 1111, seg = 1111111, dp = 1 throughout. After release, the first frame shows 0 on all digits with an sequence 1110, 1101, 1011, 0111, each held for 4 cycles.
- Snapshot coherency: apply min_ten..sec_one = 1,2,5,9 before the first 3→0 advance. The next frame shows:
  - an = 1110 with seg = 0010000 (9);
  - an = 1101 with seg = 0010010 (5);
  - an = 1011 with seg = 0100100 and dp = 0;
  - an = 0111 with seg = 1111001.
  Changing the inputs mid-frame leaves the frame unchanged until the next 3→0 advance.
- Invalid BCD: sec_one = 4'hC → seg = 1111111 while an = 1110.
- Blink seconds: adjust = 1, blink_sel = 0 → seconds digits are visible for the first 8 cycles, then an[1:0] stay high for the next 8 cycles while minutes digits keep scanning; the pattern repeats.
- Blink minutes and adjust release: with blink_sel = 1, idx = 2 in the blank phase → an = 1111 and dp = 1. Drop adjust → on the next edge the digit reappears and phase = 0.
- Mid-frame reset: assert reset while idx = 2 → outputs are 1111/1111111 at the next edge. After release, scanning restarts at an = 1110 and snap = 0.
